// File: rtl/gpu_write_scheduler.sv
// gpu_write_scheduler
//   Queues register writes from two requesters (CPU and sprite/palette DMA)
//   into a small FIFO and replays them onto the GPU write port only while the
//   display is blanked. Each write is a SETUP / STROBE / HOLD sequence so that
//   address and data are stable around the whole gpu_w pulse.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   cpu_req/addr/data     CPU write request (held until cpu_ack)
//   cpu_ack               one-cycle pulse: the CPU request was queued
//   dma_req/addr/data     DMA write request (held until dma_ack)
//   dma_ack               one-cycle pulse: the DMA request was queued
//   blank                 high outside the visible display area
//   gpu_addr/data/w       registered GPU write port
//   busy                  queue non-empty or a write still in progress
//   level                 current queue occupancy
module gpu_write_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [11:0] dma_addr,
    input  logic [7:0]  dma_data,
    output logic        dma_ack,
    input  logic        blank,
    output logic [11:0] gpu_addr,
    output logic [7:0]  gpu_data,
    output logic        gpu_w,
    output logic        busy,
    output logic [4:0]  level
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH       = 5'(FIFO_DEPTH);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state;
    state_t        state_next;
    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          prio;
    logic [3:0]    strobe_cnt;
    logic          cpu_elig;
    logic          dma_elig;
    logic          grant_cpu;
    logic          grant_dma;
    logic          push;
    logic          pop;
    logic          gpu_w_next;
    logic [19:0]   push_entry;

    // A requester keeps req high during its ack cycle, so it is ignored in that
    // cycle; otherwise the same write would be queued twice. prio=0 favours CPU.
    always_comb begin
        pop        = (state == IDLE) && (level != 5'd0) && blank;
        cpu_elig   = cpu_req && !cpu_ack;
        dma_elig   = dma_req && !dma_ack;
        grant_cpu  = cpu_elig && (!dma_elig || !prio);
        grant_dma  = dma_elig && (!cpu_elig || prio);
        push       = (grant_cpu || grant_dma) && ((level < DEPTH) || pop);
        push_entry = grant_cpu ? {cpu_addr, cpu_data} : {dma_addr, dma_data};
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= 5'd0;
            prio    <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            cpu_ack <= push && grant_cpu;
            dma_ack <= push && grant_dma;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                prio   <= grant_cpu;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // gpu_w is registered from the next state so it rises exactly on STROBE
    // entry and falls on STROBE exit without any combinational path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (strobe_cnt == 4'd0) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        gpu_w_next = (state_next == STROBE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpu_w      <= 1'b0;
            gpu_addr   <= 12'd0;
            gpu_data   <= 8'd0;
            strobe_cnt <= 4'd0;
        end else begin
            gpu_w <= gpu_w_next;
            if (pop) begin
                {gpu_addr, gpu_data} <= mem[rd_ptr];
            end
            if (state == SETUP) begin
                strobe_cnt <= STROBE_LOAD;
            end else if ((state == STROBE) && (strobe_cnt != 4'd0)) begin
                strobe_cnt <= strobe_cnt - 4'd1;
            end
        end
    end

    assign busy = (level != 5'd0) || (state != IDLE);

endmodule

// File: tb/tb_gpu_write_scheduler.sv
// tb_gpu_write_scheduler
//   Directed bench for gpu_write_scheduler. Three instances share the inputs:
//   the default one (STROBE_CYCLES=2) drives the requester model through its
//   acks, the other two (1 and 15) are used for strobe width and spacing.
//   Monitors record every gpu_w pulse (rise cycle, width, address/data).
module tb_gpu_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, dma_req, blank;
    logic [11:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_data, dma_data;

    logic        cpu_ack, dma_ack, gpu_w, busy;
    logic [11:0] gpu_addr;
    logic [7:0]  gpu_data;
    logic [4:0]  level;

    logic        s1_cpu_ack, s1_dma_ack, s1_gpu_w, s1_busy;
    logic [11:0] s1_gpu_addr;
    logic [7:0]  s1_gpu_data;
    logic [4:0]  s1_level;

    logic        s15_cpu_ack, s15_dma_ack, s15_gpu_w, s15_busy;
    logic [11:0] s15_gpu_addr;
    logic [7:0]  s15_gpu_data;
    logic [4:0]  s15_level;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpu_write_scheduler #(.FIFO_DEPTH(4), .STROBE_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
        .blank(blank), .gpu_addr(gpu_addr), .gpu_data(gpu_data), .gpu_w(gpu_w),
        .busy(busy), .level(level)
    );

    gpu_write_scheduler #(.FIFO_DEPTH(4), .STROBE_CYCLES(1)) dut_s1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(s1_cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(s1_dma_ack),
        .blank(blank), .gpu_addr(s1_gpu_addr), .gpu_data(s1_gpu_data), .gpu_w(s1_gpu_w),
        .busy(s1_busy), .level(s1_level)
    );

    gpu_write_scheduler #(.FIFO_DEPTH(4), .STROBE_CYCLES(15)) dut_s15 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(s15_cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(s15_dma_ack),
        .blank(blank), .gpu_addr(s15_gpu_addr), .gpu_data(s15_gpu_data), .gpu_w(s15_gpu_w),
        .busy(s15_busy), .level(s15_level)
    );

    // Pulse monitors: sampled on the falling edge, away from the active edge.
    logic        w0_prev = 1'b0, w1_prev = 1'b0, w2_prev = 1'b0;
    int          h0_cur = 0, h1_cur = 0, h2_cur = 0;
    logic [19:0] wq[$];
    int          rise0[$], rise1[$], rise2[$];
    int          high0[$], high1[$], high2[$];

    always @(negedge clk) begin
        if (gpu_w === 1'b1 && w0_prev !== 1'b1) begin
            wq.push_back({gpu_addr, gpu_data});
            rise0.push_back(cyc);
            h0_cur = 1;
        end else if (gpu_w === 1'b1) begin
            h0_cur++;
        end else if (w0_prev === 1'b1) begin
            high0.push_back(h0_cur);
        end
        w0_prev = gpu_w;
    end

    always @(negedge clk) begin
        if (s1_gpu_w === 1'b1 && w1_prev !== 1'b1) begin
            rise1.push_back(cyc);
            h1_cur = 1;
        end else if (s1_gpu_w === 1'b1) begin
            h1_cur++;
        end else if (w1_prev === 1'b1) begin
            high1.push_back(h1_cur);
        end
        w1_prev = s1_gpu_w;
    end

    always @(negedge clk) begin
        if (s15_gpu_w === 1'b1 && w2_prev !== 1'b1) begin
            rise2.push_back(cyc);
            h2_cur = 1;
        end else if (s15_gpu_w === 1'b1) begin
            h2_cur++;
        end else if (w2_prev === 1'b1) begin
            high2.push_back(h2_cur);
        end
        w2_prev = s15_gpu_w;
    end

    // Requester model: holds req/addr/data through the ack cycle, then moves
    // to its next write (or drops req) on the following cycle.
    int          cpu_idx, cpu_lim, dma_idx, dma_lim, cpu_acks, dma_acks;
    bit          cpu_flag, dma_flag;
    logic [11:0] cpu_abase, dma_abase;
    logic [7:0]  cpu_dbase, dma_dbase;
    int          ack_log[$];

    task automatic start_requests(input int cl, input logic [11:0] ca, input logic [7:0] cd,
                                  input int dl, input logic [11:0] da, input logic [7:0] dd);
        cpu_lim = cl; cpu_abase = ca; cpu_dbase = cd; cpu_idx = 0; cpu_flag = 0; cpu_acks = 0;
        dma_lim = dl; dma_abase = da; dma_dbase = dd; dma_idx = 0; dma_flag = 0; dma_acks = 0;
        ack_log.delete();
    endtask

    task automatic step();
        @(negedge clk);
        if (cpu_flag) begin cpu_idx++; cpu_flag = 0; end
        if (dma_flag) begin dma_idx++; dma_flag = 0; end
        cpu_req  = (cpu_idx < cpu_lim);
        cpu_addr = cpu_abase + 12'(cpu_idx);
        cpu_data = cpu_dbase + 8'(cpu_idx);
        dma_req  = (dma_idx < dma_lim);
        dma_addr = dma_abase + 12'(dma_idx);
        dma_data = dma_dbase + 8'(dma_idx);
        if (cpu_ack === 1'b1) begin cpu_flag = 1; cpu_acks++; ack_log.push_back(0); end
        if (dma_ack === 1'b1) begin dma_flag = 1; dma_acks++; ack_log.push_back(1); end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        blank = 1'b0;
        start_requests(0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (cpu_idx >= cpu_lim && dma_idx >= dma_lim && !cpu_flag && !dma_flag &&
                busy === 1'b0 && s1_busy === 1'b0 && s15_busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        blank = 1'b0;
        start_requests(0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
        step();
        step();
        tests_run++; if (gpu_w !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gpu_w: got %b expected 0", gpu_w); end
        tests_run++; if (gpu_addr !== 12'h0) begin tests_failed++; $display("[TB] FAIL reset_gpu_addr: got %h expected 000", gpu_addr); end
        tests_run++; if (gpu_data !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_gpu_data: got %h expected 00", gpu_data); end
        tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
        tests_run++; if (dma_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dma_ack: got %b expected 0", dma_ack); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0]  ack_v, w_v, busy_v;
        logic [4:0]  lvl1, lvl2;
        logic [11:0] addr3;
        logic [7:0]  data3;
        int          hb;
        do_reset();
        blank = 1'b1;
        hb = high0.size();
        start_requests(1, 12'hF12, 8'hA5, 0, 12'h0, 8'h0);
        ack_v = '0; w_v = '0; busy_v = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            ack_v  = {ack_v[6:0], cpu_ack};
            w_v    = {w_v[6:0], gpu_w};
            busy_v = {busy_v[6:0], busy};
            if (k == 1) lvl1 = level;
            if (k == 2) lvl2 = level;
            if (k == 3) begin addr3 = gpu_addr; data3 = gpu_data; end
        end
        tests_run++; if (ack_v !== 8'b0100_0000) begin tests_failed++; $display("[TB] FAIL single_ack_seq: got %b expected 01000000", ack_v); end
        tests_run++; if (w_v !== 8'b0001_1000) begin tests_failed++; $display("[TB] FAIL single_gpu_w_seq: got %b expected 00011000", w_v); end
        tests_run++; if (busy_v !== 8'b0111_1100) begin tests_failed++; $display("[TB] FAIL single_busy_seq: got %b expected 01111100", busy_v); end
        tests_run++; if (lvl1 !== 5'd1) begin tests_failed++; $display("[TB] FAIL single_level_push: got %0d expected 1", lvl1); end
        tests_run++; if (lvl2 !== 5'd0) begin tests_failed++; $display("[TB] FAIL single_level_pop: got %0d expected 0", lvl2); end
        tests_run++; if (addr3 !== 12'hF12) begin tests_failed++; $display("[TB] FAIL single_addr: got %h expected F12", addr3); end
        tests_run++; if (data3 !== 8'hA5) begin tests_failed++; $display("[TB] FAIL single_data: got %h expected A5", data3); end
        tests_run++; if (high0.size() != hb + 1) begin tests_failed++; $display("[TB] FAIL single_pulses: got %0d expected 1", high0.size() - hb); end
        else begin
            tests_run++; if (high0[hb] != 2) begin tests_failed++; $display("[TB] FAIL single_width: got %0d expected 2", high0[hb]); end
        end
    endtask

    task automatic test_contention();
        bit          ok;
        int          wb;
        logic [19:0] exp;
        do_reset();
        blank = 1'b1;
        wb = wq.size();
        start_requests(4, 12'h100, 8'h10, 4, 12'h200, 8'h80);
        wait_idle(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL contention_timeout: got busy %b expected idle", busy); end
        tests_run++; if (ack_log.size() != 8) begin tests_failed++; $display("[TB] FAIL contention_ack_count: got %0d expected 8", ack_log.size()); end
        for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
            tests_run++; if (ack_log[i] != i % 2) begin tests_failed++; $display("[TB] FAIL contention_ack%0d: got %0d expected %0d (0=CPU 1=DMA)", i, ack_log[i], i % 2); end
        end
        tests_run++; if (wq.size() != wb + 8) begin tests_failed++; $display("[TB] FAIL contention_writes: got %0d expected 8", wq.size() - wb); end
        for (int i = 0; i < 8 && wb + i < wq.size(); i++) begin
            if (i % 2 == 0) exp = {12'h100 + 12'(i / 2), 8'h10 + 8'(i / 2)};
            else            exp = {12'h200 + 12'(i / 2), 8'h80 + 8'(i / 2)};
            tests_run++; if (wq[wb + i] !== exp) begin tests_failed++; $display("[TB] FAIL contention_write%0d: got %h expected %h", i, wq[wb + i], exp); end
        end
    endtask

    task automatic test_full();
        bit          ok;
        int          wb;
        logic [19:0] exp;
        do_reset();
        blank = 1'b0;
        wb = wq.size();
        start_requests(5, 12'h300, 8'h30, 0, 12'h0, 8'h0);
        for (int k = 0; k < 12; k++) step();
        tests_run++; if (cpu_acks != 4) begin tests_failed++; $display("[TB] FAIL full_acks: got %0d expected 4", cpu_acks); end
        tests_run++; if (level !== 5'd4) begin tests_failed++; $display("[TB] FAIL full_level: got %0d expected 4", level); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_busy: got %b expected 1", busy); end
        tests_run++; if (wq.size() != wb) begin tests_failed++; $display("[TB] FAIL full_no_write: got %0d expected 0", wq.size() - wb); end
        blank = 1'b1;
        step();
        tests_run++; if (cpu_acks != 5) begin tests_failed++; $display("[TB] FAIL full_fifth_ack: got %0d expected 5", cpu_acks); end
        tests_run++; if (level !== 5'd4) begin tests_failed++; $display("[TB] FAIL full_level_pushpop: got %0d expected 4", level); end
        tests_run++; if ({gpu_addr, gpu_data} !== {12'h300, 8'h30}) begin tests_failed++; $display("[TB] FAIL full_first_pop: got %h expected 30030", {gpu_addr, gpu_data}); end
        wait_idle(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL full_timeout: got busy %b expected idle", busy); end
        tests_run++; if (wq.size() != wb + 5) begin tests_failed++; $display("[TB] FAIL full_writes: got %0d expected 5", wq.size() - wb); end
        for (int i = 0; i < 5 && wb + i < wq.size(); i++) begin
            exp = {12'h300 + 12'(i), 8'h30 + 8'(i)};
            tests_run++; if (wq[wb + i] !== exp) begin tests_failed++; $display("[TB] FAIL full_write%0d: got %h expected %h", i, wq[wb + i], exp); end
        end
    endtask

    task automatic test_blank_gating();
        bit ok;
        bit seen;
        int wb, hb;
        do_reset();
        blank = 1'b1;
        wb = wq.size();
        hb = high0.size();
        start_requests(2, 12'h400, 8'h40, 0, 12'h0, 8'h0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (gpu_w === 1'b1) seen = 1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL blank_strobe_timeout: got gpu_w %b expected 1", gpu_w); end
        blank = 1'b0;
        for (int k = 0; k < 20; k++) step();
        tests_run++; if (wq.size() != wb + 1) begin tests_failed++; $display("[TB] FAIL blank_gated_writes: got %0d expected 1", wq.size() - wb); end
        tests_run++; if (high0.size() != hb + 1) begin tests_failed++; $display("[TB] FAIL blank_completed: got %0d expected 1", high0.size() - hb); end
        else begin
            tests_run++; if (high0[hb] != 2) begin tests_failed++; $display("[TB] FAIL blank_width: got %0d expected 2", high0[hb]); end
        end
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("[TB] FAIL blank_level: got %0d expected 1", level); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL blank_busy: got %b expected 1", busy); end
        blank = 1'b1;
        wait_idle(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL blank_timeout: got busy %b expected idle", busy); end
        tests_run++; if (wq.size() != wb + 2) begin tests_failed++; $display("[TB] FAIL blank_resumed_writes: got %0d expected 2", wq.size() - wb); end
        else begin
            tests_run++; if (wq[wb + 1] !== {12'h401, 8'h41}) begin tests_failed++; $display("[TB] FAIL blank_second_write: got %h expected 40141", wq[wb + 1]); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        int wb;
        do_reset();
        blank = 1'b0;
        start_requests(4, 12'h500, 8'h50, 0, 12'h0, 8'h0);
        for (int k = 0; k < 10; k++) step();
        tests_run++; if (level !== 5'd4) begin tests_failed++; $display("[TB] FAIL midrst_fill: got %0d expected 4", level); end
        blank = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (gpu_w === 1'b1) seen = 1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL midrst_strobe_timeout: got gpu_w %b expected 1", gpu_w); end
        tests_run++; if (level !== 5'd3) begin tests_failed++; $display("[TB] FAIL midrst_level_before: got %0d expected 3", level); end
        reset = 1'b1;
        step();
        tests_run++; if (gpu_w !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_gpu_w: got %b expected 0", gpu_w); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("[TB] FAIL midrst_level: got %0d expected 0", level); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        wb = wq.size();
        for (int k = 0; k < 20; k++) step();
        tests_run++; if (wq.size() != wb) begin tests_failed++; $display("[TB] FAIL midrst_no_writes: got %0d expected 0", wq.size() - wb); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_stay_idle: got %b expected 0", busy); end
    endtask

    task automatic test_strobe_sweep();
        bit ok;
        int r0, r1, r2, h0, h1, h2;
        do_reset();
        blank = 1'b1;
        r0 = rise0.size(); r1 = rise1.size(); r2 = rise2.size();
        h0 = high0.size(); h1 = high1.size(); h2 = high2.size();
        start_requests(2, 12'h600, 8'h60, 0, 12'h0, 8'h0);
        wait_idle(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL sweep_timeout: got busy %b/%b/%b expected idle", busy, s1_busy, s15_busy); end
        tests_run++; if (rise0.size() != r0 + 2 || high0.size() != h0 + 2) begin tests_failed++; $display("[TB] FAIL sweep2_pulses: got %0d expected 2", rise0.size() - r0); end
        else begin
            tests_run++; if (high0[h0] != 2 || high0[h0 + 1] != 2) begin tests_failed++; $display("[TB] FAIL sweep2_width: got %0d,%0d expected 2,2", high0[h0], high0[h0 + 1]); end
            tests_run++; if (rise0[r0 + 1] - rise0[r0] != 5) begin tests_failed++; $display("[TB] FAIL sweep2_spacing: got %0d expected 5", rise0[r0 + 1] - rise0[r0]); end
        end
        tests_run++; if (rise1.size() != r1 + 2 || high1.size() != h1 + 2) begin tests_failed++; $display("[TB] FAIL sweep1_pulses: got %0d expected 2", rise1.size() - r1); end
        else begin
            tests_run++; if (high1[h1] != 1 || high1[h1 + 1] != 1) begin tests_failed++; $display("[TB] FAIL sweep1_width: got %0d,%0d expected 1,1", high1[h1], high1[h1 + 1]); end
            tests_run++; if (rise1[r1 + 1] - rise1[r1] != 4) begin tests_failed++; $display("[TB] FAIL sweep1_spacing: got %0d expected 4", rise1[r1 + 1] - rise1[r1]); end
        end
        tests_run++; if (rise2.size() != r2 + 2 || high2.size() != h2 + 2) begin tests_failed++; $display("[TB] FAIL sweep15_pulses: got %0d expected 2", rise2.size() - r2); end
        else begin
            tests_run++; if (high2[h2] != 15 || high2[h2 + 1] != 15) begin tests_failed++; $display("[TB] FAIL sweep15_width: got %0d,%0d expected 15,15", high2[h2], high2[h2 + 1]); end
            tests_run++; if (rise2[r2 + 1] - rise2[r2] != 18) begin tests_failed++; $display("[TB] FAIL sweep15_spacing: got %0d expected 18", rise2[r2 + 1] - rise2[r2]); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        blank    = 1'b0;
        cpu_req  = 1'b0; cpu_addr = 12'h0; cpu_data = 8'h0;
        dma_req  = 1'b0; dma_addr = 12'h0; dma_data = 8'h0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_blank_gating();
        test_reset_mid_write();
        test_strobe_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpu_write_scheduler.md
GPU_WRITE_SCHEDULER -- requirements
Module: gpu_write_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): pending-write queue entries.
REQ-002 SHALL have parameter STROBE_CYCLES, default 2 (1..15): cycles gpu_w is held high per write.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req  input  1, cpu_addr  input  12, cpu_data  input  8: CPU write request, with its GPU register address and data.
REQ-006 SHALL have port cpu_ack  output  1  one-cycle pulse; the CPU request was enqueued.
REQ-007 SHALL have ports dma_req  input  1, dma_addr  input  12, dma_data  input  8: sprite/palette loader write request.
REQ-008 SHALL have port dma_ack  output  1  one-cycle pulse; the DMA request was enqueued.
REQ-009 SHALL have port blank  input  1  high while the display is outside the visible area (sync/porch lines or columns).
REQ-010 SHALL have ports gpu_addr  output  12, gpu_data  output  8, gpu_w  output  1: GPU write port; the GPU samples on the gpu_w rising edge.
REQ-011 SHALL have port busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-012 SHALL have port level  output  5  current FIFO occupancy (0..FIFO_DEPTH).

Function
REQ-013 Requesters SHALL hold req, addr and data stable until they see ack; the requester deasserts req on the cycle after ack, or holds it to issue a back-to-back write.
REQ-014 At most one request SHALL be enqueued per cycle; an enqueue requires level < FIFO_DEPTH, or a same-cycle pop.
REQ-015 Arbitration SHALL be round-robin with a one-bit priority pointer; after a grant the pointer points to the other requester; the pointer resets to CPU.
REQ-016 With a single requester, it SHALL be granted regardless of the pointer.
REQ-017 ack SHALL assert in the cycle after the enqueue condition holds at a clock edge; an {addr,data} entry is written on that same edge.
REQ-018 When the FIFO is full, no ack SHALL be issued and requests SHALL wait; no entry is dropped or overwritten.
REQ-019 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
- IDLE: when the FIFO is non-empty and blank=1, pop the head entry into the output registers, then go to SETUP.
- SETUP: gpu_addr/gpu_data driven, gpu_w=0, lasts 1 cycle, then go to STROBE.
- STROBE: gpu_w=1 for exactly STROBE_CYCLES cycles (down-counter), then go to HOLD.
- HOLD: gpu_w=0 with addr/data unchanged for 1 cycle, then go to IDLE.
REQ-020 A write SHALL therefore occupy STROBE_CYCLES+2 cycles after the pop; the next pop is possible in the IDLE cycle that follows.
REQ-021 gpu_addr and gpu_data SHALL be registered and change only on a pop; they are stable from SETUP through HOLD.
REQ-022 If blank falls after a pop, the write SHALL still complete; no new pop occurs while blank=0.
REQ-023 FIFO order SHALL be strict FIFO, with pointers wrapping modulo FIFO_DEPTH; a simultaneous push and pop leaves level unchanged.
REQ-024 gpu_w SHALL be a register output and glitch-free.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL set:
- FSM = IDLE, FIFO pointers = 0, level = 0, priority = CPU;
- gpu_w = 0, gpu_addr = 0, gpu_data = 0;
- cpu_ack = dma_ack = 0, busy = 0.
REQ-026 A reset mid-write SHALL drop gpu_w on the next edge and discard all queued entries.

Verification
REQ-027 Single write: blank=1, cpu_req with addr=F12, data=A5 -> cpu_ack 1 cycle later; gpu_w high for 2 cycles with gpu_addr=F12 and gpu_data=A5; busy returns to 0.
REQ-028 Contention: cpu_req and dma_req held continuously with distinct data, blank=1 -> acks alternate CPU,DMA,CPU,DMA…; GPU writes appear in the same order.
REQ-029 Full: blank=0, 5 CPU requests -> 4 acks, level=4, 5th request waits; blank=1 -> 5 writes in order, 5th ack arrives after the first pop.
REQ-030 Blank gating: blank drops during STROBE -> the current write completes; the next queued write starts only after blank=1 again.
REQ-031 Reset mid-write: reset during STROBE with level=3 -> next cycle gpu_w=0, level=0, busy=0; no further writes are issued.
REQ-032 Parameter sweep: STROBE_CYCLES=1 and 15 -> gpu_w high-time equals the parameter; spacing between writes is STROBE_CYCLES+3 cycles.
